nibble_serializer: RTL and testbench
====================================

# nibble_serializer

Upstream feeder for the serial bit comparator stage: accepts a pair of WIDTH-bit operands over a valid/ready handshake and shifts them out MSB-first, one bit pair per clock, on the comparator's two serial inputs. It frames each operand pair with first/last strobes so the downstream stage knows where a comparison starts and ends. It supports back-to-back pairs with no idle cycle between frames.

## Interface
- WIDTH, 4, operand width in bits (≥2); the counter is $clog2(WIDTH) bits wide.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ns_valid  in  1  upstream offers an operand pair.
- ns_ready  out  1  block can accept a pair this cycle (combinational from state).
- ns_a  in  WIDTH  operand A, sampled on accept.
- ns_b  in  WIDTH  operand B, sampled on accept.
- ns_bit_a  out  1  serial A bit, MSB first; drives the comparator's a input.
- ns_bit_b  out  1  serial B bit, MSB first; drives the comparator's b input.
- ns_bit_valid  out  1  ns_bit_a/ns_bit_b carry a live bit.
- ns_first  out  1  the current bit is the MSB of a frame.
- ns_last  out  1  the current bit is the LSB of a frame.

## Operation
- Reset: state IDLE, both shift registers 0, counter 0. ns_bit_a = ns_bit_b = ns_bit_valid = ns_first = ns_last = 0, ns_ready = 1.
- Accept = ns_valid & ns_ready.
- State machine:
  - IDLE: ns_ready = 1. On accept, load sh_a <= ns_a, sh_b <= ns_b, cnt <= WIDTH-1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: ns_bit_valid = 1. Each cycle with cnt != 0: shift both registers left (zero fill), cnt <= cnt-1.
  - SHIFT with cnt == 0: ns_ready = 1.
    - On accept: reload both registers, cnt <= WIDTH-1, stay in SHIFT (back-to-back).
    - Otherwise: clear both registers and go to IDLE.
- Output decode:
  - ns_bit_a = sh_a[WIDTH-1] and ns_bit_b = sh_b[WIDTH-1], both taken straight from register bits.
  - ns_first = SHIFT & (cnt == WIDTH-1).
  - ns_last = SHIFT & (cnt == 0).
  - ns_bit_valid = SHIFT.
- In IDLE both serial bits are 0. The comparator treats 00 as "equal bits, hold", so idle cycles never disturb its selector.
- ns_valid while ns_ready = 0: ignored. ns_a/ns_b are not sampled and upstream must hold the pair.
- Operands are unsigned; no arithmetic is performed, and bit order is strictly MSB to LSB.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously) and the partial frame is discarded. The first bit after reset release belongs only to a newly accepted pair.

## Timing
- Accept at rising edge N: the MSB pair is visible during cycle N+1 with ns_first = 1. The LSB pair is visible during cycle N+WIDTH with ns_last = 1.
- Frame length is exactly WIDTH cycles. Throughput is one pair per WIDTH cycles when back-to-back.
- ns_ready is high in IDLE and in the ns_last cycle, and low in every other cycle.
- Back-to-back: an accept during the ns_last cycle puts the next frame's MSB (ns_first = 1) in the very next cycle, with no bubble.
- The downstream comparator registers its inputs, so its result for a frame is final one cycle after ns_last.
- WIDTH = 2 degenerate case: ns_first and ns_last fall in adjacent cycles and are never high together.

## Test plan
- Reset: assert RESET mid-clock -> all outputs 0 and ns_ready = 1 immediately (before the next edge); hold 3 cycles -> no change.
- Single frame, WIDTH = 4, ns_a = 4'b1010, ns_b = 4'b0110 -> cycles N+1..N+4 give bit_a = 1,0,1,0 and bit_b = 0,1,1,0, with first only at N+1, last only at N+4, then IDLE with bits 0.
- Back-to-back: second pair 4'b0001 / 4'b0011 accepted during the last cycle -> its MSB appears at N+5 with ns_first = 1, ns_bit_valid stays high for 8 consecutive cycles, and ns_ready is high only at N+4 and N+8.
- Busy rejection: hold ns_valid with 4'b1111 / 4'b0000 during cycles N+1..N+3 -> ns_ready = 0 and the serial stream is unchanged; the pair is accepted at N+4 and streams from N+5.
- Reset mid-frame: assert RESET at cycle N+2 -> outputs 0, state IDLE. New pair 4'b1100 / 4'b1100 after release -> full 4-cycle frame streams out from its MSB, with bit_a equal to bit_b every cycle.
- Parameter sweep, WIDTH = 2 and 8 -> frame length equals WIDTH, with first/last placement and MSB-first order checked against a scoreboard.

Source files
------------

// File: rtl/nibble_serializer.sv
// nibble_serializer: shifts accepted operand pairs out MSB-first as framed bit pairs
module nibble_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ns_valid,
  output logic             ns_ready,
  input  logic [WIDTH-1:0] ns_a,
  input  logic [WIDTH-1:0] ns_b,
  output logic             ns_bit_a,
  output logic             ns_bit_b,
  output logic             ns_bit_valid,
  output logic             ns_first,
  output logic             ns_last
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             shifting, at_last;
  assign shifting     = state == SHIFT;
  assign at_last      = cnt == '0;
  assign ns_ready     = !shifting || at_last;
  assign ns_bit_a     = sh_a[WIDTH-1];
  assign ns_bit_b     = sh_b[WIDTH-1];
  assign ns_bit_valid = shifting;
  assign ns_first     = shifting && cnt == CW'(WIDTH-1);
  assign ns_last      = shifting && at_last;
  // load on accept, shift while bits remain, clear the registers when a frame ends without a follower
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else if (ns_valid && ns_ready) begin
      state <= SHIFT;
      sh_a  <= ns_a;
      sh_b  <= ns_b;
      cnt   <= CW'(WIDTH-1);
    end else if (shifting) begin
      if (!at_last) begin
        sh_a <= {sh_a[WIDTH-2:0], 1'b0};
        sh_b <= {sh_b[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end else begin
        sh_a  <= '0;
        sh_b  <= '0;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: directed checks of framing, back-to-back, busy, reset and width sweep
module tb_nibble_serializer;
  logic CLK = 1'b0, RESET = 1'b1;
  int total = 0, bad = 0;
  logic v4 = 0, rdy, bv, fst, lst, ba, bb;
  logic [3:0] a4 = '0, b4 = '0;
  logic v2 = 0, r2, bv2, f2, l2, ba2, bb2;
  logic [1:0] a2 = '0, b2 = '0;
  logic v8 = 0, r8, bv8, f8, l8, ba8, bb8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] pa2 [2] = '{2'b10, 2'b11};
  logic [1:0] pb2 [2] = '{2'b01, 2'b00};
  logic [1:0] ea2, eb2;
  logic [7:0] ea8 = 8'hA5, eb8 = 8'h3C;

  always #5 CLK = ~CLK;

  nibble_serializer #(.WIDTH(4)) dut4 (.CLK(CLK), .RESET(RESET), .ns_valid(v4), .ns_ready(rdy),
    .ns_a(a4), .ns_b(b4), .ns_bit_a(ba), .ns_bit_b(bb), .ns_bit_valid(bv), .ns_first(fst), .ns_last(lst));
  nibble_serializer #(.WIDTH(2)) dut2 (.CLK(CLK), .RESET(RESET), .ns_valid(v2), .ns_ready(r2),
    .ns_a(a2), .ns_b(b2), .ns_bit_a(ba2), .ns_bit_b(bb2), .ns_bit_valid(bv2), .ns_first(f2), .ns_last(l2));
  nibble_serializer #(.WIDTH(8)) dut8 (.CLK(CLK), .RESET(RESET), .ns_valid(v8), .ns_ready(r8),
    .ns_a(a8), .ns_b(b8), .ns_bit_a(ba8), .ns_bit_b(bb8), .ns_bit_valid(bv8), .ns_first(f8), .ns_last(l8));

  // outputs packed as {ready, bit_valid, first, last, bit_a, bit_b}
  function automatic logic [5:0] o4();
    return {rdy, bv, fst, lst, ba, bb};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("in_reset", o4(), 6'b100000);
    RESET = 1'b0;
    step();
    chk("idle", o4(), 6'b100000);
    // single frame 1010 / 0110
    v4 = 1; a4 = 4'b1010; b4 = 4'b0110;
    step(); v4 = 0;
    chk("s1", o4(), 6'b011010);
    step(); chk("s2", o4(), 6'b010001);
    step(); chk("s3", o4(), 6'b010011);
    step(); chk("s4", o4(), 6'b110100);
    step(); chk("s_idle", o4(), 6'b100000);
    // back-to-back with 0001 / 0011 accepted in the last cycle
    v4 = 1; a4 = 4'b1010; b4 = 4'b0110;
    step(); v4 = 0;
    chk("b1", o4(), 6'b011010);
    step(); chk("b2", o4(), 6'b010001);
    step(); chk("b3", o4(), 6'b010011);
    v4 = 1; a4 = 4'b0001; b4 = 4'b0011;
    step(); chk("b4", o4(), 6'b110100);
    step(); v4 = 0;
    chk("b5", o4(), 6'b011000);
    step(); chk("b6", o4(), 6'b010000);
    step(); chk("b7", o4(), 6'b010001);
    step(); chk("b8", o4(), 6'b110111);
    step(); chk("b_idle", o4(), 6'b100000);
    // busy rejection: 1111 / 0000 held while the first frame streams
    v4 = 1; a4 = 4'b1010; b4 = 4'b0110;
    step(); a4 = 4'b1111; b4 = 4'b0000;
    chk("r1", o4(), 6'b011010);
    step(); chk("r2", o4(), 6'b010001);
    step(); chk("r3", o4(), 6'b010011);
    step(); chk("r4", o4(), 6'b110100);
    step(); v4 = 0;
    chk("r5", o4(), 6'b011010);
    step(); chk("r6", o4(), 6'b010010);
    step(); chk("r7", o4(), 6'b010010);
    step(); chk("r8", o4(), 6'b110110);
    step(); chk("r_idle", o4(), 6'b100000);
    // reset mid-frame, asserted between edges
    v4 = 1; a4 = 4'b1100; b4 = 4'b1100;
    step(); v4 = 0;
    chk("m1", o4(), 6'b011011);
    step(); chk("m2", o4(), 6'b010011);
    #2 RESET = 1'b1;
    #1 chk("m_async", o4(), 6'b100000);
    for (int i = 0; i < 3; i++) begin
      step(); chk("m_hold", o4(), 6'b100000);
    end
    RESET = 1'b0;
    step(); chk("m_rel", o4(), 6'b100000);
    v4 = 1;
    step(); v4 = 0;
    chk("n1", o4(), 6'b011011);
    step(); chk("n2", o4(), 6'b010011);
    step(); chk("n3", o4(), 6'b010000);
    step(); chk("n4", o4(), 6'b110100);
    step(); chk("n_idle", o4(), 6'b100000);
    // WIDTH=2 back-to-back frames
    v2 = 1; a2 = pa2[0]; b2 = pb2[0];
    step();
    for (int f = 0; f < 2; f++) begin
      ea2 = pa2[f]; eb2 = pb2[f];
      for (int i = 0; i < 2; i++) begin
        chk("w2", {r2, bv2, f2, l2, ba2, bb2},
            {i == 1, 1'b1, i == 0, i == 1, ea2[1-i], eb2[1-i]});
        if (i == 0 && f == 0) begin a2 = pa2[1]; b2 = pb2[1]; end
        if (i == 0 && f == 1) v2 = 0;
        step();
      end
    end
    chk("w2_idle", {r2, bv2, f2, l2, ba2, bb2}, 6'b100000);
    // WIDTH=8 single frame
    v8 = 1; a8 = ea8; b8 = eb8;
    step(); v8 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("w8", {r8, bv8, f8, l8, ba8, bb8},
          {i == 7, 1'b1, i == 0, i == 7, ea8[7-i], eb8[7-i]});
      step();
    end
    chk("w8_idle", {r8, bv8, f8, l8, ba8, bb8}, 6'b100000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
